// File: rtl/parity_frame_rx.sv
// Bit-serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Define PARITY_RX_ERR_COUNT_EN to add a saturating 8-bit error counter output.
module parity_frame_rx #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_bit,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef PARITY_RX_ERR_COUNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_q, acc_d;
  logic               mismatch_q, mismatch_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               data_valid_q, data_valid_d;
  logic               parity_err_q, parity_err_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= 1'b0;
      mismatch_q   <= 1'b0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mismatch_q   <= mismatch_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // Everything advances only on strobed edges; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mismatch_d   = mismatch_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (!rx_bit) begin
            shift_d = '0;
            cnt_d   = '0;
            acc_d   = 1'b0;
            state_d = DATA;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) shift_d[i] = rx_bit;
          end
          acc_d = acc_q ^ rx_bit;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = PARITY;
        end
        PARITY: begin
          mismatch_d = acc_q ^ rx_bit ^ ODD;
          state_d    = STOP;
        end
        STOP: begin
          // A bad stop bit drops the word but keeps the previously delivered one.
          if (rx_bit) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            parity_err_d = mismatch_q;
          end else begin
            frame_err_d  = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

`ifdef PARITY_RX_ERR_COUNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else if ((parity_err_q || frame_err_q) && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: an even-parity and an odd-parity receiver share one
// serial stream and are checked against a frame-level model.
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxBit;
  logic       rxValid;
  logic [7:0] data, dataOdd;
  logic       dataValid, parityErr, frameErr, busy;
  logic       dataValidOdd, parityErrOdd, frameErrOdd, busyOdd;
`ifdef PARITY_RX_ERR_COUNT_EN
  logic [7:0] errCount, errCountOdd;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  // Results captured by sendFrame at the stop-bit edge
  logic [7:0] gotData, gotDataOdd;
  logic       gotDv, gotPe, gotFe, gotBusy, gotPeOdd, gotDvOdd, gotFeOdd;
  int         busyCount;
  int         spurious;
  int         holdBad;

  typedef struct {
    logic [7:0] word;
    logic       parBit;
    logic       stopBit;
    logic [7:0] expData;
    logic       expDv;
    logic       expPe;
    logic       expPeOdd;
    logic       expFe;
  } vec_t;

  vec_t vecs[9];

  parity_frame_rx #(.DATA_W(8), .ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .rx_bit(rxBit), .rx_valid(rxValid),
    .data(data), .data_valid(dataValid), .parity_err(parityErr),
    .frame_err(frameErr), .busy(busy)
`ifdef PARITY_RX_ERR_COUNT_EN
    , .err_count(errCount)
`endif
  );

  parity_frame_rx #(.DATA_W(8), .ODD(1'b1)) dutOdd (
    .clk(clk), .rst(rst), .rx_bit(rxBit), .rx_valid(rxValid),
    .data(dataOdd), .data_valid(dataValidOdd), .parity_err(parityErrOdd),
    .frame_err(frameErrOdd), .busy(busyOdd)
`ifdef PARITY_RX_ERR_COUNT_EN
    , .err_count(errCountOdd)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the rising edge
  task automatic applyStimulus(input logic b, input logic v);
    @(negedge clk);
    rxBit   = b;
    rxValid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst     = 1'b1;
    rxBit   = 1'b0;
    rxValid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst     = 1'b0;
    rxValid = 1'b0;
    rxBit   = 1'b1;
  endtask

  // Sends start, 8 data bits, parity, stop; optional idle gaps (rx_valid=0)
  task automatic sendFrame(input logic [7:0] w, input logic p, input logic s,
                           input int gapAfter, input int gapLen, input int stopGap,
                           input bit randGaps);
    logic [10:0] bits;
    int          idle;
    bits      = {s, p, w, 1'b0};
    busyCount = 0;
    spurious  = 0;
    holdBad   = 0;
    for (int k = 0; k < 11; k++) begin
      idle = 0;
      if (k == gapAfter + 1) idle += gapLen;
      if (k == 10) idle += stopGap;
      if (randGaps && $urandom_range(0, 3) == 0) idle += $urandom_range(1, 3);
      for (int g = 0; g < idle; g++) begin
        applyStimulus(1'($urandom), 1'b0);
        if (k > 0 && (busy !== 1'b1 || busyOdd !== 1'b1)) holdBad++;
        if (k > 0 && (dataValid || parityErr || frameErr)) holdBad++;
      end
      applyStimulus(bits[k], 1'b1);
      if (k < 10) begin
        if (busy === 1'b1) busyCount++;
        if (dataValid || parityErr || frameErr || dataValidOdd || parityErrOdd || frameErrOdd)
          spurious++;
      end
    end
    gotData    = data;
    gotDataOdd = dataOdd;
    gotDv      = dataValid;
    gotPe      = parityErr;
    gotFe      = frameErr;
    gotBusy    = busy;
    gotPeOdd   = parityErrOdd;
    gotDvOdd   = dataValidOdd;
    gotFeOdd   = frameErrOdd;
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] expData, input logic expDv,
                            input logic expPe, input logic expPeOdd, input logic expFe);
    checkOutput({tag, ".data"}, int'(gotData), int'(expData));
    checkOutput({tag, ".dataValid"}, int'(gotDv), int'(expDv));
    checkOutput({tag, ".parityErr"}, int'(gotPe), int'(expPe));
    checkOutput({tag, ".frameErr"}, int'(gotFe), int'(expFe));
    checkOutput({tag, ".busyAfterStop"}, int'(gotBusy), 0);
    checkOutput({tag, ".parityErrOdd"}, int'(gotPeOdd), int'(expPeOdd));
    checkOutput({tag, ".oddAgrees"}, int'({gotDataOdd, gotDvOdd, gotFeOdd}),
                int'({expData, expDv, expFe}));
    checkOutput({tag, ".busyCycles"}, busyCount, 10);
    checkOutput({tag, ".noEarlyPulse"}, spurious, 0);
    checkOutput({tag, ".gapHold"}, holdBad, 0);
  endtask

  initial begin
    logic [7:0] modelData;
    logic [7:0] w;
    logic       p, s;
    int         ones;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};

    rst     = 1'b1;
    rxBit   = 1'b1;
    rxValid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.data", int'(data), 0);
    checkOutput("reset.dataValid", int'(dataValid), 0);
    checkOutput("reset.parityErr", int'(parityErr), 0);
    checkOutput("reset.frameErr", int'(frameErr), 0);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.busyOdd", int'(busyOdd), 0);
    @(negedge clk);
    rst     = 1'b0;
    rxValid = 1'b0;

    // Table frames sent back to back with continuous strobes
    foreach (vecs[i]) begin
      sendFrame(vecs[i].word, vecs[i].parBit, vecs[i].stopBit, 0, 0, 0, 1'b0);
      checkFrame($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expDv,
                 vecs[i].expPe, vecs[i].expPeOdd, vecs[i].expFe);
    end

    // Pulses last one cycle and data holds afterwards
    sendFrame(8'hA5, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    checkFrame("good", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("pulse.dvDrops", int'(dataValid), 0);
    checkOutput("pulse.dataHolds", int'(data), 'hA5);
    sendFrame(8'hA5, 1'b1, 1'b1, 0, 0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("pulse.peDropsNoStrobe", int'(parityErr), 0);
    checkOutput("pulse.idleNoStrobe", int'(busy), 0);

    // Gaps of 3 after data bit 4 and 2 before the stop bit
    sendFrame(8'hA5, 1'b0, 1'b1, 4, 3, 2, 1'b0);
    checkFrame("gaps", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset after the 5th data bit discards the frame
    for (int k = 0; k < 6; k++) applyStimulus(k == 0 ? 1'b0 : 1'b1, 1'b1);
    checkOutput("abort.busyBefore", int'(busy), 1);
    pulseReset();
    checkOutput("abort.busy", int'(busy), 0);
    checkOutput("abort.data", int'(data), 0);
    checkOutput("abort.noPulse", int'({dataValid, parityErr, frameErr}), 0);
    sendFrame(8'h81, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    checkFrame("afterAbort", 8'h81, 1'b1, 1'b0, 1'b1, 1'b0);

    // Randomized frames against a frame-level model
    modelData = 8'h81;
    for (int n = 0; n < 40; n++) begin
      w    = 8'($urandom);
      p    = 1'($urandom);
      s    = ($urandom_range(0, 3) != 0);
      ones = $countones(w) + int'(p);
      if (s) modelData = w;
      sendFrame(w, p, s, 0, 0, 0, 1'b1);
      checkFrame($sformatf("rand%0d", n), modelData, s,
                 s && (ones % 2 != 0), s && (ones % 2 != 1), !s);
    end

`ifdef PARITY_RX_ERR_COUNT_EN
    for (int n = 0; n < 260; n++) sendFrame(8'h01, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("errCount.saturated", int'(errCount), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial receiver and parity checker for the parity-protected frames built by the team's XOR/XNOR parity-generation logic. It deframes a bit-serial stream (start bit, DATA_W data bits LSB first, one parity bit, one stop bit) sampled on a per-bit strobe. It recomputes parity with an XOR accumulator and presents the recovered word with parity and framing error flags. It sits at the receiving end of the parity link, feeding downstream logic one word per frame.

## Interface
- DATA_W, default 8: data bits per frame, range 1–16.
- ODD, default 0: 0 = even parity (total ones across data + parity bit even); 1 = odd parity.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- rx_bit  input  1  serial line value.
- rx_valid  input  1  strobe; rx_bit is sampled only on edges where rx_valid=1.
- data  output  DATA_W  last accepted word; holds between frames.
- data_valid  output  1  one-cycle pulse: new word on data.
- parity_err  output  1  one-cycle pulse, concurrent with data_valid, when parity mismatches.
- frame_err  output  1  one-cycle pulse when the stop bit reads 0.
- busy  output  1  high in any state other than IDLE.

## Operation
- Reset (rst=1 at an edge): state IDLE, data=0, data_valid=0, parity_err=0, frame_err=0, busy=0, bit counter=0, parity accumulator=0.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on edges with rx_valid=1; with rx_valid=0 all state, counters and accumulator hold, and pulses deassert.
- IDLE: rx_bit=1 -> stay (line idle). rx_bit=0 -> start bit accepted: clear shift register, counter and accumulator; go to DATA.
- DATA: shift rx_bit in LSB first (first data bit lands in bit 0). Update acc <= acc ^ rx_bit and increment the counter. After the DATA_W-th bit, go to PARITY.
- PARITY: store mismatch = acc ^ rx_bit ^ ODD. A nonzero result is a parity error. Go to STOP.
- STOP:
  - rx_bit=1: data <= shift register, data_valid=1, parity_err=stored mismatch.
  - rx_bit=0: frame_err=1. data_valid and parity_err stay 0; data holds its previous value.
  - Either case returns to IDLE.
- A word with a parity error is still delivered (data_valid=1) so downstream logic can decide what to do with it.
- A framing error does not re-sync on that bit. The next rx_bit=0 seen in IDLE is treated as a new start bit.
- Bit counter width is ceil(log2(DATA_W+1)). The counter never wraps within a frame.

## Timing
- All outputs are registered. Pulses are asserted for the single cycle following the edge that samples the stop bit, and deassert on the next edge.
- Latency: data, data_valid and parity_err update on the same edge that samples the stop bit.
- Minimum frame length is DATA_W+3 valid strobes. Back-to-back frames are allowed: a start bit sampled on the strobe right after the stop bit is accepted.
- rx_valid may have arbitrary gaps, including mid-frame. Gaps have no effect other than holding state.
- rst has priority over rx_valid. Reset mid-frame discards the partial frame and produces no pulses.
- busy rises on the edge accepting the start bit and falls on the edge sampling the stop bit.

## Configuration
- PARITY_RX_ERR_COUNT_EN defined:
  - Adds output err_count, 8 bits, reset 0.
  - Increments by 1 on each cycle where parity_err or frame_err is 1.
  - Saturates at 255 and never wraps.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Even parity, DATA_W=8, continuous rx_valid. Frame 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB first, parity 0, stop 1) -> data=0xA5, data_valid=1 for one cycle, parity_err=0, frame_err=0; busy high for exactly 10 cycles.
- Same frame with parity bit 1 -> data=0xA5, data_valid=1, parity_err=1.
- 0x3C frame with correct parity but stop bit 0, following a good 0xA5 frame -> frame_err=1, data_valid=0, data remains 0xA5.
- 0xA5 frame with rx_valid low for 3 cycles after data bit 4 and 2 cycles before the stop bit -> identical result to the first scenario; state holds during the gaps.
- rst pulsed after the 5th data bit, then a full 0x81 frame -> no pulses from the aborted frame; then data=0x81, data_valid=1, parity_err=0.
- ODD=1, frame 0x00 with parity 1 -> parity_err=0. With PARITY_RX_ERR_COUNT_EN defined, 260 frames with bad parity -> err_count=255.
